nmos_tr_counter: RTL and testbench

Parametrised two-phase synchronous counter built from chained NMOS toggle stages. It counts up or down, loads in parallel and flags terminal count. Each bit has a PHI2 master stage and a PHI1 output stage, all sampled on the simulation main clock. It replaces hand-wired chains of single-bit toggle registers in counter, divider and timer cells of the NMOS models.

---
 rtl/nmos_tr_counter.sv | 56 +++++
 tb/tb_nmos_tr_counter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/nmos_tr_counter.sv
// Two-phase up/down counter: a PHI2 master register computes the next count from the
// PHI1 output register, which copies the master on PHI1. Both are clocked by _clk.
module nmos_tr_counter #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             _clk,
    input  logic             R,
    input  logic             C1,
    input  logic             C2,
    input  logic             T,
    input  logic             UD,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_n,
    output logic             CO
);

    logic [WIDTH-1:0] ph2;
    logic [WIDTH-1:0] ph1;
    logic [WIDTH:0]   up_chain;
    logic [WIDTH:0]   dn_chain;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] count_nxt;

    // Ripple toggle chains: bit i flips when all lower bits are 1 (up) or 0 (down).
    assign up_chain[0] = T;
    assign dn_chain[0] = T;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        assign up_chain[i+1] = up_chain[i] & ph1[i];
        assign dn_chain[i+1] = dn_chain[i] & ~ph1[i];
        assign toggle[i]     = UD ? dn_chain[i] : up_chain[i];
    end

    assign count_nxt = ph1 ^ toggle;

    always_ff @(posedge _clk) begin
        if (R) begin
            ph2 <= RST_VAL;
            ph1 <= RST_VAL;
        end else begin
            if (C2)
                ph2 <= LD ? D : count_nxt;
            if (C1)
                ph1 <= ph2;
        end
    end

    assign Q   = ph1;
    assign Q_n = ~ph1;
    // The last chain element is exactly "T and every bit at its terminal value".
    assign CO  = UD ? dn_chain[WIDTH] : up_chain[WIDTH];

endmodule

// File: tb/tb_nmos_tr_counter.sv
// Bench for nmos_tr_counter: 4-bit and 8-bit instances share stimulus and are checked
// every cycle against an arithmetic model, plus literal expectations from directed steps.
module tb_nmos_tr_counter;

    logic       clk;
    logic       R, C1, C2, T, UD, LD;
    logic [7:0] d8;
    logic [3:0] q4, qn4;
    logic [7:0] q8, qn8;
    logic       co4, co8;

    int checks = 0;
    int errors = 0;
    bit valid  = 0;

    // model state: master/output for each instance
    int unsigned m4_2, m4_1, m8_2, m8_1;

    initial clk = 0;
    always #5 clk = ~clk;

    nmos_tr_counter #(.WIDTH(4), .RST_VAL(4'h5)) u4 (
        ._clk(clk), .R(R), .C1(C1), .C2(C2), .T(T), .UD(UD), .LD(LD),
        .D(d8[3:0]), .Q(q4), .Q_n(qn4), .CO(co4)
    );

    nmos_tr_counter #(.WIDTH(8), .RST_VAL(8'h00)) u8 (
        ._clk(clk), .R(R), .C1(C1), .C2(C2), .T(T), .UD(UD), .LD(LD),
        .D(d8), .Q(q8), .Q_n(qn8), .CO(co8)
    );

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned next_master(input int unsigned m1, input int unsigned m2,
                                                input int unsigned mask, input int unsigned d);
        if (!C2) return m2;
        if (LD) return d & mask;
        if (!T) return m1;
        return UD ? ((m1 + mask) & mask) : ((m1 + 1) & mask);
    endfunction

    always @(posedge clk) begin
        int unsigned n4, n8;
        if (R) begin
            m4_2 = 5; m4_1 = 5; m8_2 = 0; m8_1 = 0;
        end else begin
            n4 = next_master(m4_1, m4_2, 32'hF, d8);
            n8 = next_master(m8_1, m8_2, 32'hFF, d8);
            if (C1) begin m4_1 = m4_2; m8_1 = m8_2; end
            m4_2 = n4; m8_2 = n8;
        end
    end

    always @(negedge clk) begin
        if (valid) begin
            chk("q4", q4, m4_1);
            chk("qn4", qn4, ~m4_1 & 32'hF);
            chk("co4", co4, T && (UD ? (m4_1 == 0) : (m4_1 == 32'hF)));
            chk("ph2_4", u4.ph2, m4_2);
            chk("q8", q8, m8_1);
            chk("qn8", qn8, ~m8_1 & 32'hFF);
            chk("co8", co8, T && (UD ? (m8_1 == 0) : (m8_1 == 32'hFF)));
        end
    end

    task automatic step(input logic c1, input logic c2);
        C1 = c1; C2 = c2;
        @(posedge clk); #2;
        C1 = 0; C2 = 0;
    endtask

    task automatic pair();
        step(0, 1);
        step(1, 0);
    endtask

    task automatic load(input logic [7:0] v);
        LD = 1; d8 = v; pair(); LD = 0;
    endtask

    initial begin
        R = 1; C1 = 0; C2 = 0; T = 1; UD = 0; LD = 1; d8 = 8'h0A;
        @(posedge clk); #2;
        // reset wins over load/count on a C2 edge
        step(0, 1);
        chk("rst_q", q4, 4'h5);
        chk("rst_qn", qn4, 4'hA);
        chk("rst_ph2", u4.ph2, 4'h5);
        valid = 1;
        R = 0;

        load(8'h00);
        chk("up_start", q4, 0);
        T = 1; UD = 0;
        for (int k = 1; k <= 17; k++) begin
            pair();
            chk("up_q", q4, k % 16);
            if (k == 15) chk("up_co_f", co4, 1);
            if (k == 16) chk("up_co_0", co4, 0);
        end

        T = 0; load(8'h00);
        T = 1; UD = 1;
        #1 chk("dn_co_before", co4, 1);
        pair();
        chk("dn_q", q4, 4'hF);
        chk("dn_co_after", co4, 0);

        T = 0; UD = 0; load(8'h03);
        chk("ld_q3", q4, 4'h3);
        T = 1; load(8'h09);
        chk("ld_pri", q4, 4'h9);
        T = 0;
        for (int k = 0; k < 3; k++) pair();
        chk("hold", q4, 4'h9);

        load(8'h02);
        T = 1; UD = 0;
        for (int k = 0; k < 3; k++) step(0, 1);
        chk("c2_only", q4, 4'h2);
        step(1, 0);
        chk("c1_after", q4, 4'h3);
        step(1, 1);
        chk("both_q", q4, 4'h3);
        chk("both_ph2", u4.ph2, 4'h4);

        T = 0; load(8'h7E);
        chk("mid_pre", q8, 8'h7E);
        T = 1; R = 1;
        step(0, 1);
        chk("mid_rst", q8, 8'h00);
        R = 0;
        pair();
        chk("mid_resume", q8, 8'h01);

        for (int k = 0; k < 400; k++) begin
            R  = ($urandom_range(0, 31) == 0);
            T  = $urandom_range(0, 3) != 0;
            UD = $urandom_range(0, 1);
            LD = ($urandom_range(0, 7) == 0);
            d8 = 8'($urandom);
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        R = 0; LD = 0; T = 0;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
